branch_squash_ctrl: RTL

BRANCH_SQUASH_CTRL -- requirements
Module: branch_squash_ctrl

---
 rtl/branch_squash_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/branch_squash_ctrl.sv
// Branch squash controller: holds the oldest mispredicted branch
// and emits a one-cycle squash when that branch retires.

package branch_squash_pkg;

    localparam int ROB_IDX_BITS = 7;
    localparam int FTQ_IDX_BITS = 6;

    typedef logic [ROB_IDX_BITS-1:0] robIdx_t;
    typedef logic [FTQ_IDX_BITS-1:0] ftqIdx_t;

    typedef struct packed {
        logic        has_mispred;
        logic        branch_taken;
        robIdx_t     rob_idx;
        ftqIdx_t     ftq_idx;
        logic [31:0] branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic        dueToBranch;
        logic        branch_taken;
        logic [31:0] arch_pc;
    } squashInfo_t;

endpackage

module branch_squash_ctrl
    import branch_squash_pkg::*;
#(
    parameter int BRWB_PORTS = 2,
    parameter int ROBIDX_W   = ROB_IDX_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BRWB_PORTS-1:0]               i_brwb_vld,
    input  branchwbInfo_t [BRWB_PORTS-1:0]      i_brwb,
    input  logic                                i_retire_vld,
    input  logic [ROBIDX_W-1:0]                 i_retire_rob_idx,
    input  logic                                i_flush,
    output logic                                o_squash_vld,
    output squashInfo_t                         o_squash,
    output logic                                o_pending,
    output ftqIdx_t                             o_pending_ftq_idx,
    output logic [15:0]                         o_squash_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        SQUASH = 2'd2
    } state_e;

    state_e state;
    state_e state_nxt;

    // Held mispredicted branch
    logic                rec_vld;
    logic [ROBIDX_W-1:0] rec_rob;
    ftqIdx_t             rec_ftq;
    logic                rec_taken;
    logic [31:0]         rec_npc;

    // Oldest same-cycle candidate
    logic                sel_vld;
    logic [ROBIDX_W-1:0] sel_rob;
    ftqIdx_t             sel_ftq;
    logic                sel_taken;
    logic [31:0]         sel_npc;

    logic                retire_hit;
    logic                sel_older;
    logic                sq_fire;
    logic [15:0]         squash_cnt;

    // a is older than b; the MSB is a wrap flag that inverts the order
    function automatic logic older(
        input logic [ROBIDX_W-1:0] a,
        input logic [ROBIDX_W-1:0] b
    );
        if (a[ROBIDX_W-1] == b[ROBIDX_W-1]) begin
            return a[ROBIDX_W-2:0] < b[ROBIDX_W-2:0];
        end
        return a[ROBIDX_W-2:0] > b[ROBIDX_W-2:0];
    endfunction

    // Pick the oldest mispredicted writeback; ties keep the lower port
    always_comb begin
        sel_vld   = 1'b0;
        sel_rob   = '0;
        sel_ftq   = '0;
        sel_taken = 1'b0;
        sel_npc   = '0;
        for (int p = 0; p < BRWB_PORTS; p++) begin
            if (i_brwb_vld[p] && i_brwb[p].has_mispred &&
                (!sel_vld || older(i_brwb[p].rob_idx, sel_rob))) begin
                sel_vld   = 1'b1;
                sel_rob   = i_brwb[p].rob_idx;
                sel_ftq   = i_brwb[p].ftq_idx;
                sel_taken = i_brwb[p].branch_taken;
                sel_npc   = i_brwb[p].branch_npc;
            end
        end
    end

    // Retire of the held branch, and whether a candidate beats the record
    always_comb begin
        retire_hit = (state == HELD) && rec_vld && i_retire_vld &&
                     (i_retire_rob_idx == rec_rob);
        sel_older  = sel_vld && older(sel_rob, rec_rob);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; flush always returns to IDLE
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_vld) begin
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    if (retire_hit) begin
                        state_nxt = SQUASH;
                    end
                end
                SQUASH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Held-branch record: capture, replace with older, or clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_vld   <= 1'b0;
            rec_rob   <= '0;
            rec_ftq   <= '0;
            rec_taken <= 1'b0;
            rec_npc   <= '0;
        end else if (i_flush) begin
            rec_vld   <= 1'b0;
            rec_rob   <= '0;
            rec_ftq   <= '0;
            rec_taken <= 1'b0;
            rec_npc   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_vld) begin
                        rec_vld   <= 1'b1;
                        rec_rob   <= sel_rob;
                        rec_ftq   <= sel_ftq;
                        rec_taken <= sel_taken;
                        rec_npc   <= sel_npc;
                    end
                end
                HELD: begin
                    if (!retire_hit && sel_older) begin
                        rec_vld   <= 1'b1;
                        rec_rob   <= sel_rob;
                        rec_ftq   <= sel_ftq;
                        rec_taken <= sel_taken;
                        rec_npc   <= sel_npc;
                    end
                end
                default: begin
                    rec_vld   <= 1'b0;
                    rec_rob   <= '0;
                    rec_ftq   <= '0;
                    rec_taken <= 1'b0;
                    rec_npc   <= '0;
                end
            endcase
        end
    end

    // FSM outputs: squash pulse and pending indication
    always_comb begin
        sq_fire           = (state == SQUASH) && !i_flush;
        o_squash_vld      = sq_fire;
        o_squash          = '0;
        o_pending         = (state == HELD) && rec_vld;
        o_pending_ftq_idx = '0;
        if (sq_fire) begin
            o_squash.dueToBranch  = 1'b1;
            o_squash.branch_taken = rec_taken;
            o_squash.arch_pc      = rec_npc;
        end
        if (o_pending) begin
            o_pending_ftq_idx = rec_ftq;
        end
    end

    // Saturating count of emitted branch squashes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            squash_cnt <= '0;
        end else if (sq_fire && (squash_cnt != 16'hFFFF)) begin
            squash_cnt <= squash_cnt + 16'd1;
        end
    end

    assign o_squash_cnt = squash_cnt;

endmodule
